// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stall controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    localparam logic [31:0] DMEM_ERR_RDATA = 32'h0;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Busy-cycle counter for the data-memory controller; flags the cycle that reaches TIMEOUT.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [7:0] HitVal = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed busy cycles, so the current one is number cnt_q + 1.
    assign hit = en && (cnt_q == HitVal);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Turns single-cycle core loads/stores into req/ack SRAM transactions, stalling the core meanwhile.
module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    dmem_state_e       state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              cnt_clr, cnt_en, cnt_hit;
    logic              unused_oen;

    assign unused_oen = OEN;

    dmem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .hit(cnt_hit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        stall       = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                stall   = ~CEN;
                if (!CEN) begin
                    state_d     = StBusy;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~WEN;
                    mem_addr_d  = A;
                    mem_wdata_d = ReadData2;
                end
            end
            StBusy: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                // An ack in the timeout cycle still completes the access normally.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    cnt_clr   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if (cnt_hit) begin
                    if (!mem_we_q) begin
                        rdata_d = DATA_W'(DMEM_ERR_RDATA);
                    end
                    err_d     = 1'b1;
                    cnt_clr   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ReadDataMem = rdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed vector bench for dmem_stall_ctrl built with TIMEOUT = 4.
module tb_dmem_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        CEN;
    logic        WEN;
    logic        OEN;
    logic [6:0]  A;
    logic [31:0] ReadData2;
    logic [31:0] ReadDataMem;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    dmem_stall_ctrl #(
        .ADDR_W (7),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .CEN        (CEN),
        .WEN        (WEN),
        .OEN        (OEN),
        .A          (A),
        .ReadData2  (ReadData2),
        .ReadDataMem(ReadDataMem),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {stall, mem_req, mem_we, mem_addr, mem_wdata, ReadDataMem, err}
    typedef struct {
        logic        rst;
        logic        cen;
        logic        wen;
        logic [6:0]  a;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] rd;
        logic [74:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [74:0] got;
    vec_t vecs[26];

    function automatic vec_t mk(input logic r, input logic cen, input logic wen,
                                input logic [6:0] a, input logic [31:0] wd,
                                input logic ack, input logic [31:0] rd,
                                input logic e_stall, input logic e_req, input logic e_we,
                                input logic [6:0] e_addr, input logic [31:0] e_wd,
                                input logic [31:0] e_rdm, input logic e_err);
        vec_t v;
        v.rst = r;
        v.cen = cen;
        v.wen = wen;
        v.a   = a;
        v.wd  = wd;
        v.ack = ack;
        v.rd  = rd;
        v.exp = {e_stall, e_req, e_we, e_addr, e_wd, e_rdm, e_err};
        return v;
    endfunction

    // Drive one cycle of inputs after the falling edge, then check before the rising edge.
    task automatic run(input vec_t v, input int id);
        @(negedge clk);
        rst       = v.rst;
        CEN       = v.cen;
        WEN       = v.wen;
        A         = v.a;
        ReadData2 = v.wd;
        mem_ack   = v.ack;
        mem_rdata = v.rd;
        #1;
        got = {stall, mem_req, mem_we, mem_addr, mem_wdata, ReadDataMem, err};
        total++;
        if (got !== v.exp) begin
            bad++;
            $display("FAIL vec%0d outputs got=%h expected=%h", id, got, v.exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        CEN       = 1'b0;
        WEN       = 1'b1;
        OEN       = 1'b1;
        A         = 7'h00;
        ReadData2 = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Reset (second cycle of rst with CEN low), then a 3-cycle load.
        vecs[0]  = mk(1, 0, 1, 7'h00, 32'h0,        0, 32'h0,        1, 0, 0, 7'h00, 32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 0, 1, 7'h05, 32'h0,        0, 32'h0,        1, 0, 0, 7'h00, 32'h0,        32'h0,        0);
        vecs[2]  = mk(0, 0, 1, 7'h05, 32'h0,        0, 32'h0,        1, 1, 0, 7'h05, 32'h0,        32'h0,        0);
        vecs[3]  = mk(0, 0, 1, 7'h05, 32'h0,        0, 32'h0,        1, 1, 0, 7'h05, 32'h0,        32'h0,        0);
        vecs[4]  = mk(0, 0, 1, 7'h05, 32'h0,        1, 32'hCAFE0001, 1, 1, 0, 7'h05, 32'h0,        32'h0,        0);
        vecs[5]  = mk(0, 0, 1, 7'h05, 32'h0,        0, 32'h0,        0, 0, 0, 7'h05, 32'h0,        32'hCAFE0001, 0);
        // Store acked after one cycle; its ack data must not reach ReadDataMem.
        vecs[6]  = mk(0, 0, 0, 7'h7F, 32'h12345678, 0, 32'h0,        1, 0, 0, 7'h05, 32'h0,        32'hCAFE0001, 0);
        vecs[7]  = mk(0, 0, 0, 7'h7F, 32'h12345678, 1, 32'hDEADBEEF, 1, 1, 1, 7'h7F, 32'h12345678, 32'hCAFE0001, 0);
        vecs[8]  = mk(0, 1, 0, 7'h7F, 32'h12345678, 0, 32'h0,        0, 0, 1, 7'h7F, 32'h12345678, 32'hCAFE0001, 0);
        vecs[9]  = mk(0, 1, 1, 7'h00, 32'h0,        1, 32'h11111111, 0, 0, 1, 7'h7F, 32'h12345678, 32'hCAFE0001, 0);
        // Ack in exactly the 4th busy cycle: data latched, no error.
        vecs[10] = mk(0, 0, 1, 7'h2A, 32'h0,        0, 32'h0,        1, 0, 1, 7'h7F, 32'h12345678, 32'hCAFE0001, 0);
        vecs[11] = mk(0, 0, 1, 7'h2A, 32'h0,        0, 32'h0,        1, 1, 0, 7'h2A, 32'h0,        32'hCAFE0001, 0);
        vecs[12] = mk(0, 0, 1, 7'h2A, 32'h0,        0, 32'h0,        1, 1, 0, 7'h2A, 32'h0,        32'hCAFE0001, 0);
        vecs[13] = mk(0, 0, 1, 7'h2A, 32'h0,        0, 32'h0,        1, 1, 0, 7'h2A, 32'h0,        32'hCAFE0001, 0);
        vecs[14] = mk(0, 0, 1, 7'h2A, 32'h0,        1, 32'h0BADF00D, 1, 1, 0, 7'h2A, 32'h0,        32'hCAFE0001, 0);
        vecs[15] = mk(0, 0, 1, 7'h2A, 32'h0,        0, 32'h0,        0, 0, 0, 7'h2A, 32'h0,        32'h0BADF00D, 0);
        // Load with no ack: times out after 4 busy cycles, late acks ignored.
        vecs[16] = mk(0, 0, 1, 7'h11, 32'h0,        0, 32'h0,        1, 0, 0, 7'h2A, 32'h0,        32'h0BADF00D, 0);
        vecs[17] = mk(0, 0, 1, 7'h11, 32'h0,        0, 32'h0,        1, 1, 0, 7'h11, 32'h0,        32'h0BADF00D, 0);
        vecs[18] = mk(0, 0, 1, 7'h11, 32'h0,        0, 32'h0,        1, 1, 0, 7'h11, 32'h0,        32'h0BADF00D, 0);
        vecs[19] = mk(0, 0, 1, 7'h11, 32'h0,        0, 32'h0,        1, 1, 0, 7'h11, 32'h0,        32'h0BADF00D, 0);
        vecs[20] = mk(0, 0, 1, 7'h11, 32'h0,        0, 32'h0,        1, 1, 0, 7'h11, 32'h0,        32'h0BADF00D, 0);
        vecs[21] = mk(0, 1, 1, 7'h11, 32'h0,        1, 32'h55555555, 0, 0, 0, 7'h11, 32'h0,        32'h0,        1);
        vecs[22] = mk(0, 1, 1, 7'h11, 32'h0,        1, 32'h55555555, 0, 0, 0, 7'h11, 32'h0,        32'h0,        1);
        // A successful store afterwards leaves the sticky error set.
        vecs[23] = mk(0, 0, 0, 7'h33, 32'hA5A5A5A5, 0, 32'h0,        1, 0, 0, 7'h11, 32'h0,        32'h0,        1);
        vecs[24] = mk(0, 0, 0, 7'h33, 32'hA5A5A5A5, 1, 32'h77777777, 1, 1, 1, 7'h33, 32'hA5A5A5A5, 32'h0,        1);
        vecs[25] = mk(0, 1, 0, 7'h33, 32'hA5A5A5A5, 0, 32'h0,        0, 0, 1, 7'h33, 32'hA5A5A5A5, 32'h0,        1);

        @(posedge clk);
        for (int i = 0; i < 26; i++) begin
            run(vecs[i], i);
        end

        // Reset clears err; back-to-back load then store; reset during the store's busy cycle.
        run(mk(1, 1, 1, 7'h00, 32'h0,        0, 32'h0,        0, 0, 1, 7'h33, 32'hA5A5A5A5, 32'h0,        1), 100);
        run(mk(0, 0, 1, 7'h0A, 32'h0,        0, 32'h0,        1, 0, 0, 7'h00, 32'h0,        32'h0,        0), 101);
        run(mk(0, 0, 1, 7'h0A, 32'h0,        1, 32'h13572468, 1, 1, 0, 7'h0A, 32'h0,        32'h0,        0), 102);
        run(mk(0, 0, 0, 7'h0B, 32'h87654321, 0, 32'h0,        0, 0, 0, 7'h0A, 32'h0,        32'h13572468, 0), 103);
        run(mk(0, 0, 0, 7'h0B, 32'h87654321, 0, 32'h0,        1, 0, 0, 7'h0A, 32'h0,        32'h13572468, 0), 104);
        run(mk(1, 0, 0, 7'h0B, 32'h87654321, 0, 32'h0,        1, 1, 1, 7'h0B, 32'h87654321, 32'h13572468, 0), 105);
        run(mk(0, 1, 1, 7'h00, 32'h0,        1, 32'h99999999, 0, 0, 0, 7'h00, 32'h0,        32'h0,        0), 106);
        run(mk(0, 1, 1, 7'h00, 32'h0,        0, 32'h0,        0, 0, 0, 7'h00, 32'h0,        32'h0,        0), 107);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
# dmem_stall_ctrl

Data-memory access controller between the single-cycle MIPS core's data port (CEN/WEN/A/ReadData2/ReadDataMem) and a multi-cycle data SRAM with a req/ack handshake. Each core load or store becomes one handshaked memory transaction. While the transaction is outstanding, `stall` freezes the core (PC and register-file write enable). A sticky error flag reports memory timeouts.

## Interface
- `ADDR_W`, default 7, word-address width; matches core `A`.
- `DATA_W`, default 32, data width.
- `TIMEOUT`, default 15, maximum BUSY cycles to wait for `mem_ack`; legal range 1..255.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `CEN`  in  1  core chip enable, active low; 0 requests an access.
- `WEN`  in  1  core write enable; 0 = store, 1 = load.
- `OEN`  in  1  core output enable; ignored, present for port compatibility.
- `A`  in  ADDR_W  core word address.
- `ReadData2`  in  DATA_W  core store data.
- `ReadDataMem`  out  DATA_W  load data returned to core.
- `stall`  out  1  1 = core must hold PC and suppress register write this cycle.
- `mem_req`  out  1  request to SRAM, held until acknowledged.
- `mem_we`  out  1  1 = write transaction.
- `mem_addr`  out  ADDR_W  transaction address.
- `mem_wdata`  out  DATA_W  transaction write data.
- `mem_ack`  in  1  SRAM completion, one-cycle pulse.
- `mem_rdata`  in  DATA_W  SRAM read data, valid in the `mem_ack` cycle.
- `err`  out  1  sticky timeout flag.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE.** If `CEN`=0, capture `A`, `ReadData2` and `~WEN` into `mem_addr`, `mem_wdata` and `mem_we`, then go to BUSY. Otherwise stay in IDLE.
- **BUSY.** `mem_req`=1 and the timeout counter increments every cycle.
  - `mem_ack`=1: if `mem_we`=0, latch `mem_rdata` into `ReadDataMem`. Clear the counter, go to DONE.
  - Counter reaches `TIMEOUT` with no ack: set `err`, set `ReadDataMem`=0 if the transaction is a read, go to DONE.
- **DONE.** `stall`=0 so the core commits the instruction at this edge. Then go to IDLE unconditionally; `CEN` is not sampled in DONE.
- `stall` = (IDLE and `CEN`=0) or BUSY. It is combinational from `CEN`; all other outputs are registered.
- `ReadDataMem` holds its last read value across stores and idle cycles.
- `mem_ack` outside BUSY is ignored.
- `err` clears only on `rst`.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `ReadDataMem` 0, `err` 0, counter 0. `stall` follows `CEN`.
- Access with ack after k BUSY cycles (k≥1) takes 1 IDLE cycle + k BUSY cycles + 1 DONE cycle. `stall` is high for k+1 cycles; the minimum is 2 stall cycles.
- Core inputs must stay stable while `stall`=1. The controller uses only the values captured at the IDLE→BUSY edge.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the entire time `mem_req`=1.
- `mem_req` falls in the cycle after the ack, or after the timeout cycle.
- Ack in the same cycle the counter reaches `TIMEOUT`: the ack wins and `err` is not set.
- Reset during BUSY: `mem_req` falls on the next cycle and the transaction is abandoned. A late ack is ignored.
- Back-to-back accesses: the second access enters BUSY two cycles after the first access's DONE-entry edge (DONE→IDLE→BUSY).

## Structure
- The shared package `dmem_pkg` holds:
  - the state enum (IDLE/BUSY/DONE, 2-bit);
  - `TIMEOUT_DEFAULT`;
  - the read-on-timeout constant `DMEM_ERR_RDATA` = 32'h0.
- Sub-module `dmem_timeout_cnt`: 8-bit counter with `clr`, `en` and `hit` (count == `TIMEOUT`) signals, instantiated once.
- The top level contains the FSM, capture registers and stall logic.

## Test plan
- **Reset.** Hold `rst` for 2 cycles with `CEN`=0 → all outputs at reset values. The first request enters BUSY on the first edge after `rst` falls.
- **Load.** `A`=7'h05, `WEN`=1; SRAM acks after 3 cycles with 32'hCAFE0001 → `stall` high for 4 cycles, `mem_req` high for 3 cycles, `ReadDataMem`=32'hCAFE0001 in DONE.
- **Store.** `A`=7'h7F, `ReadData2`=32'h12345678, `WEN`=0, ack after 1 cycle → `mem_we`=1, `mem_addr`=7'h7F, `mem_wdata`=32'h12345678. `ReadDataMem` is unchanged, `stall` high for 2 cycles.
- **Timeout.** `TIMEOUT`=4 with no ack → `err`=1 after 4 BUSY cycles and `ReadDataMem`=0. A later ack is ignored and `err` stays 1 until `rst`.
- **Boundary.** Ack in exactly the 4th BUSY cycle with `TIMEOUT`=4 → data latched, `err`=0.
- **Reset mid-transaction.** Back-to-back load then store, with `rst` asserted during the store's BUSY → `mem_req`=0 next cycle, state IDLE. A spurious ack afterwards is ignored.
